// File: rtl/seq_compare.sv
// -----------------------------------------------------------------------------
// seq_compare
// Multi-cycle signed/unsigned magnitude comparator for the compare/branch
// condition path. Operands are scanned MSB-first, CHUNK bits per cycle, and the
// scan stops at the first chunk that differs. Signed operands are converted to
// offset-binary at capture (MSB inverted) so the scan is always unsigned.
//
// Ports
//   clock      : clock, all state changes on the rising edge
//   reset      : synchronous, active-high reset
//   start      : request, accepted only while ready=1
//   ready      : high in IDLE only
//   in1, in2   : operands, captured on the accept edge
//   op         : relation (00 LT, 01 LE, 10 EQ, 11 NE), captured on accept
//   is_signed  : two's complement operands, captured on accept
//   done       : one-cycle pulse, result valid
//   out        : relation result, held until the next result
//   lt_flag    : in1 < in2 under the captured signedness, held with out
//   eq_flag    : in1 == in2, held with out
// -----------------------------------------------------------------------------
module seq_compare #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       op,
    input  logic             is_signed,
    output logic             done,
    output logic             out,
    output logic             lt_flag,
    output logic             eq_flag
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("seq_compare: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_LT = 2'b00,
        OP_LE = 2'b01,
        OP_EQ = 2'b10,
        OP_NE = 2'b11
    } op_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    op_e              op_q, op_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             out_q, out_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;

    function automatic logic rel(input op_e o, input logic l, input logic e);
        logic r;
        case (o)
            OP_LT:   r = l;
            OP_LE:   r = l | e;
            OP_EQ:   r = e;
            default: r = ~e;
        endcase
        return r;
    endfunction

    // Chunk mux written as a compare-per-slot loop to keep index arithmetic
    // out of the part-select.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        idx_d   = idx_q;
        out_d   = out_q;
        lt_d    = lt_q;
        eq_d    = eq_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Offset-binary: flipping the sign bit makes unsigned
                    // ordering match two's complement ordering.
                    a_d            = in1;
                    a_d[WIDTH-1]   = in1[WIDTH-1] ^ is_signed;
                    b_d            = in2;
                    b_d[WIDTH-1]   = in2[WIDTH-1] ^ is_signed;
                    op_d           = op_e'(op);
                    idx_d          = IDX_TOP;
                    state_d        = S_SCAN;
                end
            end
            S_SCAN: begin
                if (a_chunk != b_chunk) begin
                    lt_d    = (a_chunk < b_chunk);
                    eq_d    = 1'b0;
                    out_d   = rel(op_q, (a_chunk < b_chunk), 1'b0);
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    out_d   = rel(op_q, 1'b0, 1'b1);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_LT;
            idx_q   <= '0;
            out_q   <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    assign ready   = (state_q == S_IDLE);
    assign done    = (state_q == S_DONE);
    assign out     = out_q;
    assign lt_flag = lt_q;
    assign eq_flag = eq_q;

endmodule

// File: tb/tb_seq_compare.sv
// -----------------------------------------------------------------------------
// tb_seq_compare
// Self-checking bench for seq_compare (WIDTH=16, CHUNK=4). A table of directed
// vectors and a set of random vectors are driven through the start/done
// handshake; expected results and done cycles go into a scoreboard queue and
// are compared when done is observed. Hand-written sequences cover busy-start,
// held start and reset during a scan.
// -----------------------------------------------------------------------------
module tb_seq_compare;

    localparam int W   = 16;
    localparam int C   = 4;
    localparam int NCH = W / C;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [1:0]   op;
    logic         is_signed;
    logic         done;
    logic         out;
    logic         lt_flag;
    logic         eq_flag;

    seq_compare #(.WIDTH(W), .CHUNK(C)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .ready     (ready),
        .in1       (in1),
        .in2       (in2),
        .op        (op),
        .is_signed (is_signed),
        .done      (done),
        .out       (out),
        .lt_flag   (lt_flag),
        .eq_flag   (eq_flag)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        logic         sgn;
        logic         out;
        logic         lt;
        logic         eq;
        int           m;
    } vec_t;

    typedef struct {
        int   cyc;
        logic out;
        logic lt;
        logic eq;
        int   id;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [1:0] o, input logic s, input logic r,
                                input logic l, input logic e, input int m);
        vec_t v;
        v.a = a; v.b = b; v.op = o; v.sgn = s;
        v.out = r; v.lt = l; v.eq = e; v.m = m;
        return v;
    endfunction

    // Reference: native signed/unsigned compare plus first differing chunk.
    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] o, input logic s);
        vec_t         v;
        logic [W-1:0] d;
        v.a = a; v.b = b; v.op = o; v.sgn = s;
        v.lt = s ? ($signed(a) < $signed(b)) : (a < b);
        v.eq = (a == b);
        d    = a ^ b;
        v.m  = NCH;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (d[i*C +: C] != '0) begin
                v.m = NCH - i;
                break;
            end
        end
        case (o)
            2'b00:   v.out = v.lt;
            2'b01:   v.out = v.lt | v.eq;
            2'b10:   v.out = v.eq;
            default: v.out = ~v.eq;
        endcase
        return v;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("done_cycle[%0d]", e.id), cyc, e.cyc);
                chk($sformatf("out[%0d]", e.id), out, e.out);
                chk($sformatf("lt_flag[%0d]", e.id), lt_flag, e.lt);
                chk($sformatf("eq_flag[%0d]", e.id), eq_flag, e.eq);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_drain(input int id);
        for (int k = 0; k < NCH + 4 && sbq.size() != 0; k++) next_cycle();
        if (sbq.size() != 0) begin
            chk($sformatf("drain_timeout[%0d]", id), sbq.size(), 0);
            sbq.delete();
        end
    endtask

    task automatic push_exp(input int c, input logic r, input logic l, input logic e, input int id);
        exp_t x;
        x.cyc = c; x.out = r; x.lt = l; x.eq = e; x.id = id;
        sbq.push_back(x);
    endtask

    // Called at the start of an IDLE cycle; returns in the IDLE cycle after done.
    task automatic run_vec(input vec_t v, input int id);
        chk($sformatf("ready_idle[%0d]", id), ready, 1);
        in1 = v.a; in2 = v.b; op = v.op; is_signed = v.sgn; start = 1'b1;
        push_exp(cyc + v.m + 1, v.out, v.lt, v.eq, id);
        next_cycle();
        start     = 1'b0;
        in1       = W'($urandom);
        in2       = W'($urandom);
        op        = 2'($urandom);
        is_signed = 1'($urandom);
        wait_drain(id);
        chk($sformatf("hold_out[%0d]", id), out, v.out);
        chk($sformatf("idle_done_low[%0d]", id), done, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

    initial begin : main
        int           c;
        logic [W-1:0] a;
        logic [W-1:0] b;

        tbl[0]  = mk(16'hFFFF, 16'h0001, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1);
        tbl[1]  = mk(16'hFFFF, 16'h0001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        tbl[2]  = mk(16'h1234, 16'h1234, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 4);
        tbl[3]  = mk(16'h1234, 16'h1234, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        tbl[4]  = mk(16'h1234, 16'h1235, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 4);
        tbl[5]  = mk(16'h1235, 16'h1234, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        tbl[6]  = mk(16'h8000, 16'h7FFF, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1);
        tbl[7]  = mk(16'h8000, 16'h7FFF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        tbl[8]  = mk(16'h1234, 16'h1234, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 4);
        tbl[9]  = mk(16'h0F00, 16'h0E00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        tbl[10] = mk(16'h00A0, 16'h00B0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 3);
        tbl[11] = mk(16'hFFFF, 16'hFFFE, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4);

        reset = 1'b1; start = 1'b0; in1 = '0; in2 = '0; op = 2'b00; is_signed = 1'b0;
        repeat (3) next_cycle();
        reset = 1'b0;
        chk("reset_ready", ready, 1);
        chk("reset_done", done, 0);
        chk("reset_out", out, 0);
        chk("reset_lt", lt_flag, 0);
        chk("reset_eq", eq_flag, 0);

        for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

        for (int i = 0; i < 24; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 2))
                0:       b = a;
                1:       b = W'($urandom);
                default: b = a ^ (W'($urandom_range(1, 15)) << (C * $urandom_range(0, NCH - 1)));
            endcase
            run_vec(model(a, b, 2'($urandom), 1'($urandom)), 100 + i);
        end

        // start pulses while busy are dropped, not queued
        c = cyc;
        in1 = 16'h5A5A; in2 = 16'h5A5A; op = 2'b10; is_signed = 1'b0; start = 1'b1;
        push_exp(c + 5, 1'b1, 1'b0, 1'b1, 200);
        next_cycle(); start = 1'b0;
        chk("busy_ready_c1", ready, 0);
        next_cycle(); start = 1'b1; in1 = 16'h0000; in2 = 16'h0001; op = 2'b00;
        chk("busy_ready_c2", ready, 0);
        next_cycle();
        chk("busy_ready_c3", ready, 0);
        next_cycle(); start = 1'b0;
        chk("busy_ready_c4", ready, 0);
        next_cycle();
        chk("busy_ready_c5", ready, 0);
        next_cycle();
        chk("busy_ready_c6", ready, 1);
        chk("busy_sb_empty", sbq.size(), 0);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            chk($sformatf("busy_no_extra_done[%0d]", k), done, 0);
        end

        // start held high: second op accepted in the first IDLE cycle after DONE
        c = cyc;
        in1 = 16'h0101; in2 = 16'h0101; op = 2'b10; is_signed = 1'b0; start = 1'b1;
        push_exp(c + 5, 1'b1, 1'b0, 1'b1, 300);
        repeat (6) next_cycle();
        chk("held_ready_c6", ready, 1);
        in1 = 16'h0001; in2 = 16'h0002; op = 2'b00;
        push_exp(c + 11, 1'b1, 1'b1, 1'b0, 301);
        next_cycle(); start = 1'b0;
        chk("held_ready_c7", ready, 0);
        wait_drain(301);

        // reset during scan aborts the operation without a done pulse
        run_vec(model(16'hABCD, 16'hABCD, 2'b10, 1'b0), 400);
        c = cyc;
        in1 = 16'h4444; in2 = 16'h4444; op = 2'b10; is_signed = 1'b0; start = 1'b1;
        next_cycle(); start = 1'b0;
        next_cycle(); reset = 1'b1;
        next_cycle(); reset = 1'b0;
        chk("rst_mid_ready", ready, 1);
        chk("rst_mid_out", out, 0);
        chk("rst_mid_lt", lt_flag, 0);
        chk("rst_mid_eq", eq_flag, 0);
        chk("rst_mid_done_c3", done, 0);
        for (int k = 4; k <= 8; k++) begin
            next_cycle();
            chk($sformatf("rst_mid_done_c%0d", k), done, 0);
        end

        next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
